// File: rtl/mips_defs.sv
// Shared MIPS definitions: MD-unit op encodings, instruction fields and the
// opcode/funct constants reused by the hazard unit and the E-stage decoder.
package mips_defs;

    typedef enum logic [2:0] {
        MD_MULTU = 3'd0,
        MD_MULT  = 3'd1,
        MD_DIVU  = 3'd2,
        MD_DIV   = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSVD6 = 3'd6,
        MD_RSVD7 = 3'd7
    } md_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // True for any SPECIAL-class funct that touches the MD unit or HI/LO.
    function automatic logic is_md_funct(input logic [5:0] funct);
        unique case (funct)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the HI/LO shadow values.
module md_arith
    import mips_defs::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_s_next_o,
    output logic [31:0] lo_s_next_o,
    output logic        div0_o
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        b_zero;
    logic [31:0] divisor;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    always_comb begin
        prod_u = {32'b0, a_i} * {32'b0, b_i};
        // Low 64 bits of the product of sign-extended operands equal the signed product.
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

        b_zero  = (b_i == 32'd0);
        // Substitute 1 on divide-by-zero so the dividers never see an X-producing divisor.
        divisor = b_zero ? 32'd1 : b_i;
        quot_u  = a_i / divisor;
        rem_u   = a_i % divisor;

        // Sign-magnitude divide: 0x80000000 / -1 falls out as 0x80000000, remainder 0.
        a_neg    = a_i[31];
        b_neg    = divisor[31];
        a_mag    = a_neg ? (32'd0 - a_i) : a_i;
        b_mag    = b_neg ? (32'd0 - divisor) : divisor;
        quot_mag = a_mag / b_mag;
        rem_mag  = a_mag % b_mag;
        quot_s   = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
        rem_s    = a_neg ? (32'd0 - rem_mag) : rem_mag;

        hi_s_next_o = 32'd0;
        lo_s_next_o = 32'd0;
        div0_o      = 1'b0;
        case (md_op_e'(op_i))
            MD_MULTU: {hi_s_next_o, lo_s_next_o} = prod_u;
            MD_MULT:  {hi_s_next_o, lo_s_next_o} = prod_s;
            MD_DIVU: begin
                hi_s_next_o = rem_u;
                lo_s_next_o = quot_u;
                div0_o      = b_zero;
            end
            MD_DIV: begin
                hi_s_next_o = rem_s;
                lo_s_next_o = quot_s;
                div0_o      = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs a fixed-latency busy window
// per operation and commits the precomputed shadow result at its end.
module md_unit
    import mips_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_s_q, hi_s_d;
    logic [31:0] lo_s_q, lo_s_d;
    logic        div0_q, div0_d;

    logic [31:0] hi_s_next;
    logic [31:0] lo_s_next;
    logic        div0_next;

    md_arith u_md_arith (
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .hi_s_next_o (hi_s_next),
        .lo_s_next_o (lo_s_next),
        .div0_o      (div0_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_s_d  = hi_s_q;
        lo_s_d  = lo_s_q;
        div0_d  = div0_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    case (md_op_e'(op_i))
                        MD_MULTU, MD_MULT, MD_DIVU, MD_DIV: begin
                            hi_s_d  = hi_s_next;
                            lo_s_d  = lo_s_next;
                            div0_d  = div0_next;
                            cnt_d   = (op_i[1]) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = StRun;
                        end
                        MD_MTHI: hi_d = a_i;
                        MD_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // start_i is deliberately ignored here so the in-flight op is untouched.
                if (cnt_q == 4'd1) begin
                    if (!div0_q) begin
                        hi_d = hi_s_q;
                        lo_d = lo_s_q;
                    end
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_s_q  <= 32'd0;
            lo_s_q  <= 32'd0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_s_q  <= hi_s_d;
            lo_s_q  <= lo_s_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execution unit in the E stage of the 5-stage MIPS pipeline. Implements mult, multu, div, divu, mthi and mtlo.
- Owns the architectural HI/LO registers and returns them to the E-stage result mux for mfhi/mflo.
- Publishes start/busy to the hazard unit. The hazard unit stalls any D-stage MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while start_E or busy is high.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; qualifies op, a, b.
- op  input  3  operation: 0 multu, 1 mult, 2 divu, 3 div, 4 mthi, 5 mtlo, 6/7 reserved (no-op).
- a  input  32  rs operand, already forwarded by E-stage muxes.
- b  input  32  rt operand, already forwarded.
- busy  output  1  operation in flight; HI/LO not yet committed.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (rst_n low, asynchronous): busy=0, hi=0, lo=0, counter=0, state IDLE. Reset mid-operation aborts it; no commit ever occurs for that operation.
- States: IDLE and RUN.
- IDLE with start and op in {0..3}:
  - Compute the result from a, b in the same cycle and latch it into shadow registers hi_s/lo_s.
  - Load counter with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - Go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. In the cycle counter==1:
  - next edge commits hi<=hi_s, lo<=lo_s;
  - busy drops to 0 and state returns to IDLE.
- Timing: for N = MULT_CYCLES, busy is high for exactly N cycles after the start cycle. The new hi/lo are visible in the first cycle busy is low.
- mthi/mtlo (op 4/5) with start, in IDLE:
  - op 4: hi<=a at the next edge.
  - op 5: lo<=a at the next edge.
  - No busy cycles; the other register is unchanged.
- Reserved ops 6/7: ignored; no state change.
- start while RUN: ignored. The hazard unit guarantees this cannot happen; the block must still not corrupt the in-flight operation.
- multu: {hi,lo} = unsigned a × unsigned b, full 64 bits.
- mult: {hi,lo} = signed a × signed b, two's complement 64 bits.
- divu: lo = a/b, hi = a%b, unsigned.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Special cases:
  - div with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div/divu, b=0): full busy duration runs, then hi/lo keep their prior values (no commit).
- busy is registered; no combinational path from start to busy.
- hi/lo are plain register outputs.

Decomposition:
- Shared package mips_defs:
  - MD op encodings (MD_MULTU..MD_MTLO).
  - Instruction field ranges and opcode/funct constants: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011.
  - The hazard unit and E-stage decoder reuse these constants.
- One sub-module md_arith: purely combinational; op, a, b → hi_s_next, lo_s_next, div0 flag. It contains the signed/unsigned multiply and divide plus the overflow and divide-by-zero handling.
- md_unit holds the FSM, counter, shadow registers and HI/LO.

Test Plan:
- Reset → hi=0, lo=0, busy=0. Assert rst_n low mid-RUN → busy=0 immediately, and hi/lo are 0 after release.
- start, op=1, a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo are unchanged while busy.
- start, op=0, a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- start, op=3, a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with op=3, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via op 4/5 (busy stays 0; each visible the cycle after start). Then op=2 with b=0 → busy 10 cycles, then hi=0x11, lo=0x22.
- During a mult RUN, pulse start with op=5, a=0xDEAD → ignored. Final lo equals the mult result, and busy length is unchanged.
